recip_lut_arbiter: RTL

- Shares one registered 24-bit mantissa reciprocal LUT (8-bit index in, 24-bit seed out) between NUM_REQ requesters, e.g. the divider and square-root units of the FP ALU.
- Round-robin arbitration with a valid/ready request handshake.
- Tracks in-flight lookups through a fixed-latency tag pipeline so each result returns to its originating requester.
- Full throughput: one lookup issued per cycle.

---
 rtl/recip_lut_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/recip_lut_arbiter.sv
// Round-robin arbiter sharing one registered reciprocal-seed LUT between NUM_REQ requesters.
// Optional perf counters (conflict_cycles, grant_count) are built with RECIP_LUT_ARBITER_PERF_EN.
module recip_lut_arbiter #(
  parameter int unsigned NUM_REQ     = 2,  // 2..8
  parameter int unsigned LUT_LATENCY = 1   // 1..4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_index,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 lut_in,
  input  logic [23:0]                lut_out,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [23:0]                rsp_data,
  output logic                       busy
`ifdef RECIP_LUT_ARBITER_PERF_EN
  ,
  output logic [15:0]                conflict_cycles,
  output logic [16*NUM_REQ-1:0]      grant_count
`endif
);

  localparam int unsigned IdW = $clog2(NUM_REQ);
  // One stage beyond the LUT latency so the tag lines up with the edge that samples lut_out.
  localparam int unsigned Depth = LUT_LATENCY + 1;

  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [31:0]          ptr_ext;
  logic [NUM_REQ-1:0]   scan;
  logic                 gnt;
  logic [IdW-1:0]       gnt_id;
  logic [7:0]           gnt_index;
  logic [7:0]           lut_in_q, lut_in_d;
  logic [Depth-1:0]     tag_vld_q, tag_vld_d;
  logic [Depth*IdW-1:0] tag_id_q, tag_id_d;
  logic                 last_vld;
  logic [IdW-1:0]       last_id;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]       rsp_id_q, rsp_id_d;
  logic [23:0]          rsp_data_q, rsp_data_d;
  logic                 busy_q, busy_d;

  assign ptr_ext = 32'(ptr_q);

  // Scan from the pointer upward with wrap; first valid requester wins.
  always_comb begin
    scan   = '0;
    gnt    = 1'b0;
    gnt_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = req_valid >> ((k + ptr_ext) % NUM_REQ);
      if (!gnt && scan[0]) begin
        gnt    = 1'b1;
        gnt_id = IdW'((k + ptr_ext) % NUM_REQ);
      end
    end
    if (rst) begin
      gnt = 1'b0;
    end
  end

  assign req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;
  assign gnt_index = 8'(req_index >> {gnt_id, 3'b000});

  always_comb begin
    ptr_d    = ptr_q;
    lut_in_d = lut_in_q;
    if (gnt) begin
      ptr_d    = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + IdW'(1);
      lut_in_d = gnt_index;
    end

    tag_vld_d = {tag_vld_q[Depth-2:0], gnt};
    tag_id_d  = {tag_id_q[(Depth-1)*IdW-1:0], (gnt ? gnt_id : tag_id_q[IdW-1:0])};

    last_vld = tag_vld_q[Depth-1];
    last_id  = tag_id_q[Depth*IdW-1 -: IdW];

    rsp_valid_d = last_vld ? (NUM_REQ'(1) << last_id) : '0;
    rsp_id_d    = last_id;
    rsp_data_d  = last_vld ? lut_out : rsp_data_q;

    busy_d = (|tag_vld_d) | (|rsp_valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      lut_in_q    <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      lut_in_q    <= lut_in_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign lut_in    = lut_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

`ifdef RECIP_LUT_ARBITER_PERF_EN
  logic [15:0] conflict_q;
  logic        multi_req;

  assign multi_req = ($countones(req_valid) > 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (multi_req && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cycles = conflict_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : gen_grant_cnt
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (req_ready[i] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end

    assign grant_count[16*i +: 16] = cnt_q;
  end
`endif

endmodule
